// File: rtl/serial_sub_pkg.sv
// Shared types and the single-bit subtract function for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Returns {borrow_out, difference} for one full-subtract bit.
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_sub_bit_cell.sv
// Combinational full-subtract bit cell: d = a - b - br, bo = borrow out.
module sub_bit_cell
    import serial_sub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic bo
);

    always_comb begin
        {bo, d} = sub_bit(a, b, br);
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor controller (A - B - Bin, LSB first, W cycles per operation).
// Define SERIAL_SUB_ZERO_EN to add the registered out_zero result flag.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_diff,
    output logic         out_borrow
`ifdef SERIAL_SUB_ZERO_EN
    ,
    output logic         out_zero
`endif
);

    localparam int CW = $clog2(W + 1);

    sub_state_t    state;
    sub_state_t    state_next;
    logic          accept;
    logic          last;

    logic [CW-1:0] cnt;
    logic [W-1:0]  sh_a;
    logic [W-1:0]  sh_b;
    logic [W-1:0]  res;
    logic [W-1:0]  res_next;
    logic          br;
    logic          cell_d;
    logic          cell_bo;

    sub_bit_cell u_cell (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .br (br),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(W - 1)) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // New difference bit enters at the MSB so the LSB-first stream lands in place after W shifts.
    always_comb begin
        res_next        = res >> 1;
        res_next[W-1]   = cell_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            br         <= 1'b0;
            sh_a       <= '0;
            sh_b       <= '0;
            res        <= '0;
            out_diff   <= '0;
            out_borrow <= 1'b0;
`ifdef SERIAL_SUB_ZERO_EN
            out_zero   <= 1'b0;
`endif
        end else if (accept) begin
            sh_a <= in_a;
            sh_b <= in_b;
            br   <= in_bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            br   <= cell_bo;
            res  <= res_next;
            if (last) begin
                out_diff   <= res_next;
                out_borrow <= cell_bo;
`ifdef SERIAL_SUB_ZERO_EN
                out_zero   <= (res_next == '0);
`endif
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule
